mem_ctrl_be: RTL



---
 rtl/mem_ctrl_be.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_ctrl_be.sv
// Single-port word memory with byte strobes, registered responses and a sequential clear engine.
// Latency: response 1 cycle after the accepting edge; clear takes DEPTH cycles.
// Backpressure: req_ready low while clearing; responses cannot be stalled.
module mem_ctrl_be #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    input  logic                  clr_req,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_busy
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_ready;
    logic              w_busy;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_req_idx;
    logic [IDX_W-1:0]  w_ptr_idx;
    logic [DATA_W-1:0] w_rd_word;

    assign w_accept   = req_valid & w_ready;
    assign w_in_range = ({1'b0, req_addr} < LP_DEPTH);
    assign w_req_idx  = req_addr[IDX_W-1:0];
    assign w_ptr_idx  = r_ptr[IDX_W-1:0];
    assign w_rd_word  = r_mem[w_req_idx];

    // State and clear-pointer registers; reset restarts the clear from word 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state, clear-pointer advance and handshake/busy outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_busy = 1'b1;
                // Saturating compare keeps the pointer inside the array.
                if (r_ptr >= LP_LAST) begin
                    w_ptr_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            ST_IDLE: begin
                w_ready = 1'b1;
                // A request in the same cycle is still served; the clear starts after.
                if (clr_req) begin
                    w_state_nxt = ST_INIT;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Array writes: clear engine zeroes one word per cycle, otherwise strobed request writes.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[w_ptr_idx] <= '0;
        end else if (w_accept && req_rw && w_in_range) begin
            for (int k = 0; k < NB; k++) begin
                if (req_wstrb[k]) begin
                    r_mem[w_req_idx][8*k +: 8] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    // Registered response; read data holds across write acknowledgements.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                if (!w_in_range) begin
                    r_rsp_err   <= 1'b1;
                    r_rsp_rdata <= '0;
                end else begin
                    r_rsp_err <= 1'b0;
                    if (!req_rw) begin
                        r_rsp_rdata <= w_rd_word;
                    end
                end
            end
        end
    end

    assign req_ready = w_ready;
    assign init_busy = w_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
